// File: rtl/bus_arbiter_pkg.sv
// Shared system-bus definitions: arbiter state encoding, bus widths and
// common enable/reset constants used by the arbiter and its selector.
package bus_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic RST_EN = 1'b1;
  localparam logic EN     = 1'b1;
  localparam logic DIS_EN = 1'b0;

  // Watchdog counter width: at least 8 bits, wider when the limit needs it.
  function automatic int wd_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector. Scans upward from last+1 (mod N) and
// reports the first requesting index; index `last` is examined last, so the
// previous winner only wins again when it is the sole requester.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int   cand_s;
  logic hit_s;

  // Rotating priority scan; the first hit freezes idx for the rest of the loop.
  always_comb begin
    valid  = DIS_EN;
    idx    = '0;
    cand_s = 0;
    hit_s  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s = (int'(last) + i) % N;
      hit_s  = req[cand_s] & ~valid;
      idx    = hit_s ? IDX_W'(cand_s) : idx;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter: registered one-hot grant, owner-to-slave
// multiplexer, ready/read-data return path and a per-ownership watchdog that
// forces completion when the slave never answers.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS-1:0]           m_req,
  input  logic [N_MASTERS*32-1:0]        m_addr,
  input  logic [N_MASTERS*32-1:0]        m_wr_data,
  input  logic [N_MASTERS-1:0]           m_we,
  input  logic [N_MASTERS*4-1:0]         m_sel,
  input  logic [N_MASTERS-1:0]           m_as,
  output logic [N_MASTERS-1:0]           m_grant,
  output logic [N_MASTERS-1:0]           m_ready,
  output logic [INST_DATA_BUS-1:0]       m_rd_data,
  output logic [INST_ADDR_BUS-1:0]       s_addr,
  output logic [INST_DATA_BUS-1:0]       s_wr_data,
  output logic                           s_we,
  output logic [3:0]                     s_sel,
  output logic                           s_as,
  input  logic                           s_ready,
  input  logic [INST_DATA_BUS-1:0]       s_rd_data,
  output logic                           bus_timeout
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int WD_W  = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic WD_ON = (TIMEOUT != 0);

  arb_state_t           state_r;
  logic [IDX_W-1:0]     owner_r;
  logic [IDX_W-1:0]     last_r;
  logic [N_MASTERS-1:0] grant_r;
  logic [WD_W-1:0]      wd_cnt_r;

  logic                 arb_s;
  logic                 pick_valid_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 force_s;
  logic                 owned_s;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (m_req),
    .last  (last_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign owned_s = (state_r == OWNED);
  assign m_grant = grant_r;

  // Arbitrate when idle with any request, or when the owner lets go.
  always_comb begin
    arb_s = 1'b0;
    if (owned_s) begin
      arb_s = ~m_req[owner_r];
    end else begin
      arb_s = |m_req;
    end
  end

  // Forced completion: limit reached and the slave did not answer this cycle.
  assign force_s     = WD_ON && owned_s && (wd_cnt_r == WD_LIMIT) && !s_ready;
  assign bus_timeout = force_s;

  // Ownership FSM: grant/owner/last registers plus the watchdog counter.
  always_ff @(posedge clk) begin
    if (rst == RST_EN) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      last_r   <= IDX_W'(N_MASTERS - 1);
      grant_r  <= '0;
      wd_cnt_r <= '0;
    end else if (arb_s) begin
      wd_cnt_r <= '0;
      if (pick_valid_s) begin
        state_r <= OWNED;
        owner_r <= pick_idx_s;
        last_r  <= pick_idx_s;
        grant_r <= N_MASTERS'(1) << pick_idx_s;
      end else begin
        state_r <= IDLE;
        grant_r <= '0;
      end
    end else if (!owned_s || s_ready || force_s) begin
      wd_cnt_r <= '0;
    end else begin
      wd_cnt_r <= (wd_cnt_r == {WD_W{1'b1}}) ? wd_cnt_r : wd_cnt_r + WD_W'(1);
    end
  end

  // Slave-side mux: owner's request fields while owned, all zero when idle.
  always_comb begin
    s_addr    = ZERO_WORD;
    s_wr_data = ZERO_WORD;
    s_we      = DIS_EN;
    s_sel     = 4'b0000;
    s_as      = DIS_EN;
    if (owned_s) begin
      s_addr    = m_addr[int'(owner_r)*INST_ADDR_BUS +: INST_ADDR_BUS];
      s_wr_data = m_wr_data[int'(owner_r)*INST_DATA_BUS +: INST_DATA_BUS];
      s_we      = m_we[owner_r];
      s_sel     = m_sel[int'(owner_r)*4 +: 4];
      s_as      = m_as[owner_r];
    end else begin
      s_addr    = ZERO_WORD;
      s_wr_data = ZERO_WORD;
    end
  end

  // Return path: ready goes to the owner only; a forced completion reads zero.
  always_comb begin
    m_ready = '0;
    if (owned_s) begin
      m_ready[owner_r] = s_ready | force_s;
    end else begin
      m_ready = '0;
    end
  end

  assign m_rd_data = force_s ? ZERO_WORD : s_rd_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (4 masters, watchdog limit 4).
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req;
  logic [127:0] m_addr;
  logic [127:0] m_wr_data;
  logic [3:0]   m_we;
  logic [15:0]  m_sel;
  logic [3:0]   m_as;
  logic [3:0]   m_grant;
  logic [3:0]   m_ready;
  logic [31:0]  m_rd_data;
  logic [31:0]  s_addr;
  logic [31:0]  s_wr_data;
  logic         s_we;
  logic [3:0]   s_sel;
  logic         s_as;
  logic         s_ready;
  logic [31:0]  s_rd_data;
  logic         bus_timeout;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_addr [4] = '{32'h1000_0000, 32'h2000_0000, 32'h0000_1000, 32'h4000_0000};
  logic [31:0] exp_wdat [4] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
  logic [3:0]  exp_sel  [4] = '{4'b1111, 4'b1100, 4'b0011, 4'b0001};
  logic        exp_we   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int          rot_seq  [4] = '{1, 2, 3, 0};

  bus_arbiter #(
    .N_MASTERS (4),
    .TIMEOUT   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_wr_data   (m_wr_data),
    .m_we        (m_we),
    .m_sel       (m_sel),
    .m_as        (m_as),
    .m_grant     (m_grant),
    .m_ready     (m_ready),
    .m_rd_data   (m_rd_data),
    .s_addr      (s_addr),
    .s_wr_data   (s_wr_data),
    .s_we        (s_we),
    .s_sel       (s_sel),
    .s_as        (s_as),
    .s_ready     (s_ready),
    .s_rd_data   (s_rd_data),
    .bus_timeout (bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int cur;
    logic [3:0] oh;

    rst       = 1'b1;
    m_req     = 4'b1111;
    m_as      = 4'b1111;
    m_we      = 4'b0100;
    s_ready   = 1'b0;
    s_rd_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      m_addr[i*32 +: 32]    = exp_addr[i];
      m_wr_data[i*32 +: 32] = exp_wdat[i];
      m_sel[i*4 +: 4]       = exp_sel[i];
    end

    // Reset held three cycles with everyone requesting
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_grant", {28'd0, m_grant}, 32'd0);
      chk("rst_s_as", {31'd0, s_as}, 32'd0);
    end
    chk("rst_ready", {28'd0, m_ready}, 32'd0);
    chk("rst_timeout", {31'd0, bus_timeout}, 32'd0);
    chk("rst_rdata", m_rd_data, 32'h1234_5678);
    chk("rst_s_addr", s_addr, 32'd0);
    rst = 1'b0;
    cyc();
    chk("first_grant", {28'd0, m_grant}, 32'd1);

    // Rotation 0 -> 1 -> 2 -> 3 -> 0, plus mux routing of each owner
    cur = 0;
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << cur;
      chk("rot_owner", {28'd0, m_grant}, {28'd0, oh});
      chk("mux_addr", s_addr, exp_addr[cur]);
      chk("mux_wdata", s_wr_data, exp_wdat[cur]);
      chk("mux_sel", {28'd0, s_sel}, {28'd0, exp_sel[cur]});
      chk("mux_we", {31'd0, s_we}, {31'd0, exp_we[cur]});
      chk("mux_as", {31'd0, s_as}, 32'd1);
      s_ready    = 1'b1;
      m_req[cur] = 1'b0;
      #1;
      chk("rot_ready", {28'd0, m_ready}, {28'd0, oh});
      chk("rot_rdata", m_rd_data, 32'h1234_5678);
      cyc();
      oh = 4'b0001 << rot_seq[k];
      chk("rot_next", {28'd0, m_grant}, {28'd0, oh});
      s_ready = 1'b0;
      m_req   = 4'b1111;
      cur     = rot_seq[k];
    end

    // Everyone releases: back to idle
    m_req   = 4'b0000;
    s_ready = 1'b1;
    cyc();
    s_ready = 1'b0;
    #1;
    chk("idle_grant", {28'd0, m_grant}, 32'd0);
    chk("idle_s_as", {31'd0, s_as}, 32'd0);
    chk("idle_s_addr", s_addr, 32'd0);
    chk("idle_ready", {28'd0, m_ready}, 32'd0);

    // Sole requester master 1, regranted each time with 1-cycle latency
    for (int k = 0; k < 3; k++) begin
      m_req = 4'b0010;
      cyc();
      chk("sole_grant", {28'd0, m_grant}, 32'h2);
      chk("sole_addr", s_addr, 32'h2000_0000);
      s_ready = 1'b1;
      m_req   = 4'b0000;
      #1;
      chk("sole_ready", {28'd0, m_ready}, 32'h2);
      cyc();
      chk("sole_release", {28'd0, m_grant}, 32'd0);
      s_ready = 1'b0;
    end

    // Watchdog: master 0 owns, slave silent
    m_req = 4'b0001;
    cyc();
    chk("wd_grant", {28'd0, m_grant}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk("wd_quiet", {31'd0, bus_timeout}, 32'd0);
      chk("wd_noready", {28'd0, m_ready}, 32'd0);
      cyc();
    end
    chk("wd_fire", {31'd0, bus_timeout}, 32'd1);
    chk("wd_ready", {28'd0, m_ready}, 32'h1);
    chk("wd_rdata", m_rd_data, 32'd0);
    cyc();
    chk("wd_clear", {31'd0, bus_timeout}, 32'd0);
    chk("wd_rdata_back", m_rd_data, 32'h1234_5678);

    // Second limit reached, but the slave answers in that same cycle
    cyc();
    cyc();
    cyc();
    chk("wd_pre", {31'd0, bus_timeout}, 32'd0);
    cyc();
    chk("wd_again", {31'd0, bus_timeout}, 32'd1);
    s_ready   = 1'b1;
    s_rd_data = 32'hCAFE_F00D;
    #1;
    chk("simul_timeout", {31'd0, bus_timeout}, 32'd0);
    chk("simul_rdata", m_rd_data, 32'hCAFE_F00D);
    chk("simul_ready", {28'd0, m_ready}, 32'h1);
    cyc();
    s_ready = 1'b0;
    #1;
    chk("simul_after", {31'd0, bus_timeout}, 32'd0);

    // Owner releases while two others request: rotation decides
    m_req   = 4'b1010;
    s_ready = 1'b1;
    cyc();
    chk("tie_first", {28'd0, m_grant}, 32'h2);
    m_req = 4'b1001;
    cyc();
    chk("tie_second", {28'd0, m_grant}, 32'h8);
    chk("tie_addr", s_addr, 32'h4000_0000);
    m_req = 4'b0000;
    cyc();
    chk("tie_idle", {28'd0, m_grant}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and master-to-slave multiplexer for the shared system bus. It sits directly downstream of the per-master bus interfaces: the instruction-fetch and data-memory bridges, plus up to two spare masters. It does three things:
- takes each master's `bus_req` and returns a registered one-hot grant;
- steers the granted master's address, control and write data onto the single slave-side bus;
- routes slave `ready` and read data back to that master.

A per-transaction watchdog forces completion if a slave never answers.

## Interface
Parameters:
- `N_MASTERS`, 4: number of master ports (2..4). Index 0 is the instruction-fetch bridge; index 1 is the data-memory bridge.
- `TIMEOUT`, 255: number of consecutive cycles of ownership without `s_ready` before forced completion. 0 disables the watchdog.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high (`RST_EN`).
- `m_req`  in  N_MASTERS  per-master bus request.
- `m_addr`  in  N_MASTERS×32  per-master address (`INST_ADDR_BUS`).
- `m_wr_data`  in  N_MASTERS×32  per-master write data.
- `m_we`  in  N_MASTERS  per-master write enable.
- `m_sel`  in  N_MASTERS×4  per-master byte select.
- `m_as`  in  N_MASTERS  per-master address strobe.
- `m_grant`  out  N_MASTERS  registered one-hot grant.
- `m_ready`  out  N_MASTERS  slave or forced ready, routed to the owner only.
- `m_rd_data`  out  32  read data, shared by all masters.
- `s_addr`, `s_wr_data`  out  32  to the slave decoder.
- `s_we`  out  1  to the slave decoder.
- `s_sel`  out  4  to the slave decoder.
- `s_as`  out  1  to the slave decoder.
- `s_ready`  in  1  slave completion.
- `s_rd_data`  in  32  slave read data.
- `bus_timeout`  out  1  one-cycle pulse on forced completion.

## Operation
States and registers:
- States are `IDLE` (no owner) and `OWNED`.
- `owner`: index of the current owner. `last`: index of the most recent owner.
- `wd_cnt`: watchdog counter, 8 bits minimum, wide enough to hold `TIMEOUT`.

Arbitration:
- Arbitration happens in `IDLE` when any `m_req` is high, or in `OWNED` when `m_req[owner]` is low.
- The winner is the first requesting index, scanning upward from `last+1` modulo `N_MASTERS`.
- The previous owner is checked last, so it can win again only if it is the sole requester.
- On a win: state becomes `OWNED`, `owner` and `last` are loaded, and `m_grant` becomes the one-hot of the winner.
- With no requester: state becomes `IDLE` and `m_grant` becomes 0.
- While `m_req[owner]` stays high, the grant holds, regardless of other requests.

Slave side:
- In `OWNED`, all `s_*` outputs are a combinational mux of the owner's `m_*` inputs.
- In `IDLE`, all `s_*` outputs are 0.

Return path:
- `m_ready[owner] = s_ready | force`. All other bits of `m_ready` are 0.
- `m_rd_data = force ? ZERO_WORD : s_rd_data`.

Watchdog:
- `wd_cnt` clears on reset, on a grant change, in `IDLE`, and on `s_ready` high.
- Otherwise it increments each cycle in `OWNED`.
- `force` is combinational: `TIMEOUT != 0 && wd_cnt == TIMEOUT`.
- `bus_timeout = force`. When `force` is high, `wd_cnt` clears at the next edge.

## Timing
Reset:
- At the edge with `rst` high: state `IDLE`, `m_grant` 0, `last` = `N_MASTERS-1` (so master 0 has priority first), `wd_cnt` 0.
- Consequently `s_*` are 0, `m_ready` is 0, `m_rd_data` equals `s_rd_data`, and `bus_timeout` is 0.
- Reset mid-transaction drops the grant at that same edge. No forced ready is issued.

Grant latency:
- `m_req` high in cycle t gives `m_grant` high in cycle t+1, with `s_*` valid in t+1.

Handover:
- The owner drops `m_req` in its `s_ready` cycle t.
- At the edge closing cycle t, the grant moves directly to the next requester, with zero dead cycles, or to `IDLE`.

Simultaneous events:
- All arbitration is resolved at a single edge.
- When the owner releases and two others request, rotation order decides.

Watchdog timing:
- `s_ready` and `force` are both evaluated in the same cycle. `s_ready` takes precedence: `bus_timeout` stays 0 and read data comes from the slave.

## Structure
- A shared bus package holds:
  - the state enum `{IDLE, OWNED}`;
  - the bus width constants (`INST_ADDR_BUS`, `INST_DATA_BUS`);
  - `ZERO_WORD`, `RST_EN`, `EN`, `DIS_EN`.
- One sub-module, `rr_pick`: a combinational round-robin selector (`req`, `last` → `valid`, `idx`). It is reused by future DMA arbitration.
- The mux and the watchdog stay inline.

## Test plan
- **Reset:** hold `rst` for 3 cycles with all `m_req` = 4'b1111 → `m_grant` = 0 and `s_as` = 0 during reset; `m_grant` = 4'b0001 one cycle after release.
- **Rotation:** keep all four requesting and pulse `s_ready` each transfer, with each owner dropping `m_req` for one cycle after its ready → grant order 0, 1, 2, 3, 0 with no idle cycle between owners.
- **Mux routing:** with master 2 owning, drive `m_addr[2]` = 32'h0000_1000, `m_we[2]` = 1, `m_sel[2]` = 4'b0011 → identical values on `s_*`; `m_ready` is seen only on bit 2.
- **Sole requester:** only master 1 requests, repeatedly → master 1 is regranted each time; grant latency is 1 cycle from `IDLE`.
- **Watchdog:** with `TIMEOUT` = 4, the owner requests and `s_ready` is held 0 → `bus_timeout` and `m_ready[owner]` are high exactly 4 cycles after the grant, with `m_rd_data` = 0.
- **Simultaneous ready and timeout:** `s_ready` high in the same cycle `wd_cnt` reaches `TIMEOUT` → `bus_timeout` = 0 and `m_rd_data` = `s_rd_data` (32'hCAFE_F00D).
